// File: rtl/tick_serial_shifter.sv
// Parallel-to-serial SPI-style transmitter paced by rising edges of tick_in.
// Define SHIFT_LSB_FIRST_EN to send bit 0 first; default build sends MSB first.
module tick_serial_shifter #(
  parameter int DATA_WIDTH    = 8,
  parameter int CS_HOLD_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HC_W = $clog2(CS_HOLD_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_tick_q;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_cs_n, w_cs_n_nxt;
  logic                  r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BC_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [HC_W-1:0]       r_hold_cnt, w_hold_cnt_nxt;
  logic                  w_edge;

  // Handshake: a word transfers on the clk edge where tx_valid and tx_ready are both 1;
  // tx_ready is 1 only in IDLE, and tx_data is ignored at all other times.
  assign w_edge    = tick_in & ~r_tick_q;
  assign tx_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_cs_n;
  assign done      = r_done;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt    = r_state;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_cs_n_nxt     = r_cs_n;
    w_done_nxt     = 1'b0;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_shift_nxt   = tx_data;
`ifdef SHIFT_LSB_FIRST_EN
          w_mosi_nxt    = tx_data[0];
`else
          w_mosi_nxt    = tx_data[DATA_WIDTH-1];
`endif
          w_cs_n_nxt    = 1'b0;
          w_bit_cnt_nxt = BC_W'(DATA_WIDTH - 1);
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_edge) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (w_edge) begin
          w_sclk_nxt = 1'b0;
          if (r_bit_cnt == '0) begin
            w_hold_cnt_nxt = HC_W'(CS_HOLD_TICKS - 1);
            w_state_nxt    = S_HOLD;
          end else begin
            // Data moves only on the falling sclk so it is stable at the next rise.
`ifdef SHIFT_LSB_FIRST_EN
            w_shift_nxt = r_shift >> 1;
            w_mosi_nxt  = r_shift[1];
`else
            w_shift_nxt = r_shift << 1;
            w_mosi_nxt  = r_shift[DATA_WIDTH-2];
`endif
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
            w_state_nxt   = S_SHIFT_LO;
          end
        end
      end
      S_SHIFT_LO: begin
        if (w_edge) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SHIFT_HI;
        end
      end
      S_HOLD: begin
        if (w_edge) begin
          if (r_hold_cnt == '0) begin
            w_cs_n_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_q   <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_q   <= tick_in;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_done     <= w_done_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tick_serial_shifter.sv
// Bench for tick_serial_shifter: frame-level model (tick-edge count since handshake)
// checked every clk, plus literal frame expectations for directed cases.
module tb_tick_serial_shifter;

  localparam int W           = 8;
  localparam int CS          = 1;
  localparam int FRAME_EDGES = 2 * W + CS;

`ifdef SHIFT_LSB_FIRST_EN
  localparam logic [W-1:0] EXP_SEQ_01 = 8'h80;
  localparam logic [W-1:0] EXP_SEQ_96 = 8'h69;
`else
  localparam logic [W-1:0] EXP_SEQ_01 = 8'h01;
  localparam logic [W-1:0] EXP_SEQ_96 = 8'h96;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         tick_in  = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_ready, sclk, mosi, cs_n, busy, done;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  tick_serial_shifter #(.DATA_WIDTH(W), .CS_HOLD_TICKS(CS)) dut (
    .clk(clk), .rst(rst_n), .tick_in(tick_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / tick source ----------------
  always #5 clk = ~clk;

  int   tick_mode     = 0;  // 0 divider, 1 held level, 2 random level
  int   tick_div      = 16;
  int   tick_cnt      = 0;
  logic tick_hold_val = 1'b0;

  initial forever begin
    @(negedge clk);
    case (tick_mode)
      0: begin
        tick_cnt = (tick_cnt + 1) % tick_div;
        tick_in  = (tick_cnt < tick_div / 2);
      end
      1:       tick_in = tick_hold_val;
      default: tick_in = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th transmitted bit of a word
  function automatic logic bit_at(input logic [W-1:0] w, input int k);
`ifdef SHIFT_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  // Word as seen by a receiver shifting each sampled bit in from the right
  function automatic logic [W-1:0] tx_order(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r[W-1-k] = bit_at(w, k);
    return r;
  endfunction

  // ---------------- receiver monitor ----------------
  logic         prev_sclk   = 1'b0;
  logic         prev_cs_n   = 1'b1;
  logic [W-1:0] rx_seq      = '0;
  logic [W-1:0] last_rx     = '0;
  int           rx_bits     = 0;
  int           cs_low_run  = 0;
  int           cs_high_run = 0;
  int           last_cs_low = 0;
  int           last_cs_high = 0;

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      rx_seq = '0; rx_bits = 0; prev_sclk = 1'b0;
      prev_cs_n = 1'b1; cs_low_run = 0; cs_high_run = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        rx_seq  = {rx_seq[W-2:0], mosi};
        rx_bits = rx_bits + 1;
      end
      prev_sclk = sclk;
      if (cs_n) begin
        if (!prev_cs_n) begin last_cs_low = cs_low_run; cs_low_run = 0; end
        cs_high_run++;
      end else begin
        if (prev_cs_n) begin last_cs_high = cs_high_run; cs_high_run = 0; end
        cs_low_run++;
      end
      prev_cs_n = cs_n;
      if (done) begin
        last_rx = rx_seq;
        rx_seq  = '0;
        rx_bits = 0;
      end
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  // A frame is fully described by its word and the count of tick edges since handshake.
  logic         m_busy      = 1'b0;
  logic         m_done      = 1'b0;
  logic         m_tick_q    = 1'b0;
  logic         m_last_mosi = 1'b0;
  logic [W-1:0] m_word      = '0;
  int           m_n         = 0;
  logic [W-1:0] exp_q[$];

  initial forever begin
    logic         tick_edge;
    logic [W-1:0] exp_word;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_tick_q = 1'b0; m_last_mosi = 1'b0;
      m_word = '0; m_n = 0; exp_q.delete();
    end else begin
      tick_edge = tick_in && !m_tick_q;
      m_tick_q  = tick_in;
      m_done    = 1'b0;
      if (!m_busy) begin
        if (tx_valid) begin
          m_busy = 1'b1; m_word = tx_data; m_n = 0;
          exp_q.push_back(tx_order(tx_data));
        end
      end else if (tick_edge) begin
        m_n++;
        if (m_n == FRAME_EDGES) begin
          m_busy      = 1'b0;
          m_done      = 1'b1;
          m_last_mosi = bit_at(m_word, W - 1);
          check_int("frame_bits", rx_bits, W);
          if (exp_q.size() == 0) begin
            check_int("frame_expected", 0, 1);
          end else begin
            exp_word = exp_q.pop_front();
            check_vec("frame_data", rx_seq, exp_word);
          end
        end
      end
    end
  end

  // Every clk the DUT outputs must match the model's view of the frame
  initial forever begin
    int idx;
    @(negedge clk);
    if (rst_n) begin
      idx = (m_n / 2 > W - 1) ? W - 1 : m_n / 2;
      check_bit("tx_ready", tx_ready, !m_busy);
      check_bit("busy", busy, m_busy);
      check_bit("cs_n", cs_n, !m_busy);
      check_bit("done", done, m_done);
      check_bit("sclk", sclk, m_busy && (m_n % 2 == 1) && (m_n < 2 * W));
      check_bit("mosi", mosi, m_busy ? bit_at(m_word, idx) : m_last_mosi);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check_bit("wait_idle", busy, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w);
    wait_idle(4000);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done_frame(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    check_bit("done_seen", done, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    logic [W-1:0] d;

    repeat (3) @(negedge clk);
    #1;
    check_bit("rst_cs_n", cs_n, 1'b1);
    check_bit("rst_sclk", sclk, 1'b0);
    check_bit("rst_mosi", mosi, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check_bit("post_rst_ready", tx_ready, 1'b1);

    // 0xA5 with a divide-by-16 tick
    send(8'hA5);
    wait_done_frame(4000);
    check_vec("seq_A5", last_rx, 8'hA5);
    check_bit("cs_low_range", (last_cs_low >= 256) && (last_cs_low <= 288), 1'b1);
    @(negedge clk); #1;
    check_bit("done_one_clk", done, 1'b0);

    send(8'h01);
    wait_done_frame(4000);
    check_vec("seq_01", last_rx, EXP_SEQ_01);

    // Back-to-back with tx_valid held and tx_data changed mid-frame
    wait_idle(4000);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    repeat (40) @(negedge clk);
    tx_data = 8'hC3;
    wait_done_frame(4000);
    check_vec("seq_3C", last_rx, 8'h3C);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done_frame(4000);
    check_vec("seq_C3", last_rx, 8'hC3);
    check_int("cs_gap_clks", last_cs_high, 1);

    // tx_valid pulse while busy must be ignored
    send(8'h96);
    repeat (30) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done_frame(4000);
    check_vec("seq_96", last_rx, EXP_SEQ_96);
    repeat (60) @(negedge clk);
    #1;
    check_bit("no_extra_frame", busy, 1'b0);

    // Reset after the 4th rising sclk
    send(8'h5A);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (rx_bits >= 4) break;
    end
    check_int("sclk_rises_before_rst", rx_bits, 4);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst_cs_n", cs_n, 1'b1);
    check_bit("async_rst_sclk", sclk, 1'b0);
    check_bit("async_rst_mosi", mosi, 1'b0);
    check_bit("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    check_bit("rerst_ready", tx_ready, 1'b1);
    send(8'h5A);
    wait_done_frame(4000);
    check_vec("seq_5A", last_rx, 8'h5A);

    // tick_in held high: one edge only
    tick_mode     = 1;
    tick_hold_val = 1'b0;
    repeat (3) @(negedge clk);
    send(8'hE7);
    #1 snap = rx_bits;
    tick_hold_val = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check_int("held_tick_one_edge", rx_bits - snap, 1);
    check_bit("held_tick_sclk", sclk, 1'b1);
    tick_hold_val = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_int("low_tick_no_edge", rx_bits - snap, 1);
    tick_mode = 0;
    wait_done_frame(4000);
    check_vec("seq_E7", last_rx, 8'hE7);

    // Randomized frames, tick pacing and idle gaps
    for (int i = 0; i < 40; i++) begin
      tick_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      tick_div  = $urandom_range(2, 9);
      d = W'($urandom);
      send(d);
      if ($urandom_range(0, 3) == 0) begin
        repeat (3) @(negedge clk);
        tx_data  = W'($urandom);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      wait_done_frame(4000);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    tick_mode = 0;
    wait_idle(4000);
    repeat (40) @(negedge clk);
    check_int("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_serial_shifter.md
Name: tick_serial_shifter

Overview:
- Parallel-to-serial transmitter. Takes one word per valid/ready handshake and shifts it out as a serial frame.
- Its bit timing comes entirely from the slow strobe produced by the upstream clock-divider stage, wired to tick_in.
- Outputs are an SPI-style frame (sclk, mosi, cs_n) for off-chip peripherals. All logic runs on the fast system clock; sclk is a registered output, not a clock net.

Parameters:
- DATA_WIDTH, 8: bits per frame; minimum 2.
- CS_HOLD_TICKS, 1: tick edges cs_n stays low after the last falling sclk edge; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided-clock level from the upstream divider; only its rising edges are used.
- tx_data  input  DATA_WIDTH  word to transmit; sampled at handshake.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a word.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  serial data.
- cs_n  output  1  frame select, active low.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  single-clk pulse at end of frame.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, tick_q=0, sclk=0, mosi=0, cs_n=1, done=0, shift register 0, counters 0. After release, tx_ready=1 and busy=0.
- Edge detect:
  - tick_q registers tick_in; edge = tick_in & ~tick_q.
  - tick_in held high yields exactly one edge.
  - Edge detection runs in every state, including IDLE, so the first edge after handshake is never a stale one.
- IDLE:
  - tx_ready=1.
  - When tx_valid & tx_ready: latch tx_data, drive mosi=tx_data[DATA_WIDTH-1], set cs_n=0, set bit_cnt=DATA_WIDTH-1, go to SETUP.
  - Handshake takes effect on that clk edge, with no wait for a tick.
- SETUP: on edge, sclk<=1 and go to SHIFT_HI.
- SHIFT_HI: on edge, sclk<=0.
  - If bit_cnt==0: load hold_cnt=CS_HOLD_TICKS-1 and go to HOLD.
  - Else: shift left, mosi<=next bit, bit_cnt<=bit_cnt-1, go to SHIFT_LO.
- SHIFT_LO: on edge, sclk<=1 and go to SHIFT_HI.
- HOLD: on edge:
  - If hold_cnt==0: cs_n<=1, done<=1 for one clk, go to IDLE.
  - Else: hold_cnt<=hold_cnt-1.
- Frame timing:
  - mosi changes only on falling sclk (or at handshake); the receiver samples on rising sclk.
  - One frame spans 2*DATA_WIDTH + CS_HOLD_TICKS tick edges after the handshake.
- tx_ready is 0 in every state except IDLE. tx_valid outside IDLE is ignored; no data is captured.
- done and tx_ready are both 1 in the clk after a frame ends. A held tx_valid starts the next frame on that clk, giving a back-to-back frame with cs_n high for exactly 1 clk.
- Widths: bit_cnt is $clog2(DATA_WIDTH) bits; hold_cnt is $clog2(CS_HOLD_TICKS+1) bits. Both decrement only, with no wrap.
- Reset mid-frame: all outputs go to reset values immediately. cs_n rises asynchronously and the partial frame is abandoned.
- Outputs are registered, with no combinational path from inputs, except tx_ready, which is decoded from state only.

Optional Feature:
- Macro SHIFT_LSB_FIRST_EN.
- Defined: the handshake loads mosi=tx_data[0], the register shifts right, and bits go out LSB first.
- Undefined: MSB first, as above.
- Cycle timing, cs_n and done are identical in both builds.

Test Plan:
- Upstream divider CLK_DIV=16 driving tick_in, DATA_WIDTH=8, send 0xA5 -> mosi sampled on 8 rising sclk edges is 1,0,1,0,0,1,0,1. cs_n is low for 17 edges (272 clks ±16). done pulses once, 1 clk wide.
- Same build with SHIFT_LSB_FIRST_EN, send 0xA5 -> sampled sequence 1,0,1,0,0,1,0,1 (bit0 first). Send 0x01 -> 1,0,0,0,0,0,0,0.
- tx_valid held high with 0x3C then 0xC3 -> two frames; cs_n high for exactly 1 clk between them. tx_ready is low throughout each frame. A tx_data change mid-frame does not alter mosi.
- tx_valid pulsed while busy with 0xFF -> ignored; no extra frame and no data corruption.
- rst asserted after the 4th rising sclk -> cs_n=1, sclk=0, mosi=0, busy=0 asynchronously. After release, tx_ready=1 and a fresh 0x5A frame transmits correctly.
- tick_in held high for 100 clks, then low -> only one edge counted, so the state advances by exactly one step.
